// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - multiplexed seven-segment scanner with frame-synchronous code updates
// Optional SEG_BLINK_EN adds the blink_mask port and a frame-based blink phase.
module seg7_scan_driver #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 8,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_DIGITS*7-1:0] seg_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   dig_en,
`ifdef SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic                    frame_done
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST    = IW'(NUM_DIGITS - 1);

    // Unsupported parameter sets fail elaboration on the missing module.
    if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || BLANK_CYC < 0 || SCAN_DIV <= BLANK_CYC ||
        BLINK_FRAMES < 1) begin : g_param_err
        seg7_scan_driver_illegal_parameters u_err ();
    end

    logic [PW-1:0]           presc;
    logic [IW-1:0]           idx;
    logic [NUM_DIGITS*7-1:0] shadow;
    logic [NUM_DIGITS*7-1:0] active;
    logic                    pending;
    logic                    tick;
    logic                    wrap;
    logic [6:0]              cur_code;
    logic                    cur_en;
    logic [NUM_DIGITS-1:0]   an_sel;
    logic                    blink_off;
    logic                    blank;

    assign tick = (presc == PRESC_LAST);
    assign wrap = tick && (idx == IDX_LAST);

    always_comb begin
        cur_code = 7'h7F;
        cur_en   = 1'b0;
        an_sel   = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_code  = active[7*i +: 7];
                cur_en    = dig_en[i];
                an_sel[i] = 1'b0;
            end
        end
    end

`ifdef SEG_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic          cur_blink;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_on  <= 1'b1;
        end else if (wrap) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        cur_blink = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IW'(i)) begin
                cur_blink = blink_mask[i];
            end
        end
    end

    assign blink_off = !blink_on && cur_blink;
`else
    assign blink_off = 1'b0;
`endif

    assign blank = (presc < PRESC_BLANK) || !cur_en || blink_off;

    always_ff @(posedge clk) begin
        if (rst) begin
            presc      <= '0;
            idx        <= '0;
            shadow     <= '1;
            active     <= '1;
            pending    <= 1'b0;
            seg_out    <= 7'h7F;
            an_out     <= '1;
            frame_done <= 1'b0;
        end else begin
            presc      <= tick ? '0 : presc + 1'b1;
            frame_done <= wrap;
            if (tick) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            if (load) begin
                shadow <= seg_in;
            end
            // A load coinciding with the wrap bypasses the shadow so the new frame shows it.
            if (wrap) begin
                if (load) begin
                    active <= seg_in;
                end else if (pending) begin
                    active <= shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
            seg_out <= blank ? 7'h7F : cur_code;
            an_out  <= blank ? '1 : an_sel;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - directed bench for seg7_scan_driver (4 digits, 8-cycle slots)
module tb_seg7_scan_driver;

    localparam logic [27:0] CODES_A = {7'h30, 7'h24, 7'h79, 7'h40};
    localparam logic [27:0] CODES_B = {7'h12, 7'h02, 7'h78, 7'h00};
    localparam logic [27:0] CODES_C = {7'h19, 7'h03, 7'h46, 7'h21};
    localparam logic [27:0] CODES_J = {7'h0F, 7'h0F, 7'h0F, 7'h0F};
    localparam logic [27:0] DARK    = 28'hFFF_FFFF;

    logic        clk    = 1'b0;
    logic        rst    = 1'b1;
    logic        load   = 1'b0;
    logic [27:0] seg_in = '0;
    logic [3:0]  dig_en = 4'hF;
`ifdef SEG_BLINK_EN
    logic [3:0]  blink_mask = 4'h0;
`endif
    logic [6:0]  seg_out;
    logic [3:0]  an_out;
    logic        frame_done;

    int total = 0;
    int bad   = 0;
    int n     = 0;

    seg7_scan_driver #(
        .NUM_DIGITS  (4),
        .SCAN_DIV    (8),
        .BLANK_CYC   (2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_in    (seg_in),
        .load      (load),
        .dig_en    (dig_en),
`ifdef SEG_BLINK_EN
        .blink_mask(blink_mask),
`endif
        .seg_out   (seg_out),
        .an_out    (an_out),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        n++;
    endtask

    // Outputs after edge n reflect the slot position held before that edge.
    task automatic check_cycle(input logic [27:0] codes, input logic [3:0] en);
        int         p;
        int         d;
        logic [6:0] es;
        logic [3:0] ea;
        p = (n - 1) % 8;
        d = ((n - 1) / 8) % 4;
        if (p < 2 || !en[d]) begin
            es = 7'h7F;
            ea = 4'hF;
        end else begin
            es = codes[7*d +: 7];
            ea = ~(4'b0001 << d);
        end
        chk($sformatf("seg n=%0d", n), {25'b0, seg_out}, {25'b0, es});
        chk($sformatf("an n=%0d", n), {28'b0, an_out}, {28'b0, ea});
        chk($sformatf("frame_done n=%0d", n), {31'b0, frame_done}, {31'b0, (n % 32) == 0});
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("reset seg", {25'b0, seg_out}, 32'h7F);
        chk("reset an", {28'b0, an_out}, 32'hF);
        chk("reset frame_done", {31'b0, frame_done}, 32'h0);
        rst    = 1'b0;
        load   = 1'b1;
        seg_in = CODES_A;
        n      = 0;

        for (int k = 0; k < 32; k++) begin
            step();
            check_cycle(DARK, 4'hF);
            if (n == 1) load = 1'b0;
        end

        for (int k = 0; k < 32; k++) begin
            step();
            check_cycle(CODES_A, 4'hF);
            if (n == 41) begin load = 1'b1; seg_in = CODES_J; end
            if (n == 42) load = 1'b0;
            if (n == 43) begin load = 1'b1; seg_in = CODES_B; end
            if (n == 44) load = 1'b0;
        end

        for (int k = 0; k < 32; k++) begin
            step();
            check_cycle(CODES_B, 4'hF);
            if (n == 95) begin load = 1'b1; seg_in = CODES_C; end
            if (n == 96) begin load = 1'b0; dig_en = 4'b1011; end
        end

        for (int k = 0; k < 32; k++) begin
            step();
            check_cycle(CODES_C, 4'b1011);
        end

        while (n < 146) begin
            step();
            check_cycle(CODES_C, 4'b1011);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        dig_en = 4'hF;
        n      = 0;
        chk("midreset seg", {25'b0, seg_out}, 32'h7F);
        chk("midreset an", {28'b0, an_out}, 32'hF);
        chk("midreset frame_done", {31'b0, frame_done}, 32'h0);

        for (int k = 0; k < 32; k++) begin
            step();
            check_cycle(DARK, 4'hF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
